voice_allocator: RTL and testbench

Sits between the MIDI decoder and the 8-voice polyphonic wave generator. It turns decoded MIDI note-on and note-off messages into per-voice gate commands. It tracks which voices are allocated and held, retriggers a voice that already plays a note, and steals the least-recently-allocated voice when all voices are busy. It also drives the per-voice activity LEDs.

---
 rtl/synth_pkg.sv | 28 ++
 rtl/lru_rank.sv | 47 ++++
 rtl/voice_allocator.sv | 234 +++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the voice allocator.
// Holds the MIDI status nibbles, the midi_msg field positions and the allocator FSM state type.
package synth_pkg;

  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] NOTE_OFF = 4'h8;

  // midi_msg layout: [23:16] status, [15:8] note, [7:0] velocity.
  // MIDI data bytes carry 7 bits; the top bit of each is a pad.
  localparam int unsigned MSG_TYPE_HI  = 23;
  localparam int unsigned MSG_TYPE_LO  = 20;
  localparam int unsigned MSG_CHAN_HI  = 19;
  localparam int unsigned MSG_CHAN_LO  = 16;
  localparam int unsigned MSG_NOTE_PAD = 15;
  localparam int unsigned MSG_NOTE_HI  = 14;
  localparam int unsigned MSG_NOTE_LO  = 8;
  localparam int unsigned MSG_VEL_PAD  = 7;
  localparam int unsigned MSG_VEL_HI   = 6;
  localparam int unsigned MSG_VEL_LO   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StScan,
    StIssue
  } state_e;

endpackage

// File: rtl/lru_rank.sv
// Least-recently-allocated tracker for the voice allocator.
// Keeps one rank per voice (0 = most recent, NumVoices-1 = oldest); ranks are always a permutation.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (rank[i] = i after reset)
//   touch_i        strobe: the voice at touch_idx_i was just allocated
//   touch_idx_i    voice being touched
//   max_idx_o      voice currently holding the oldest rank
module lru_rank #(
  parameter int unsigned NumVoices = 8,
  parameter int unsigned IdxW      = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            touch_i,
  input  logic [IdxW-1:0] touch_idx_i,
  output logic [IdxW-1:0] max_idx_o
);

  logic [IdxW-1:0] rank_q [NumVoices];
  logic [IdxW-1:0] touched_rank;

  assign touched_rank = rank_q[touch_idx_i];

  // Touched voice moves to rank 0; only voices that were more recent than it age by one,
  // so the ranks stay a permutation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumVoices; i++) rank_q[i] <= IdxW'(i);
    end else if (touch_i) begin
      for (int unsigned i = 0; i < NumVoices; i++) begin
        if (IdxW'(i) == touch_idx_i) begin
          rank_q[i] <= '0;
        end else if (rank_q[i] < touched_rank) begin
          rank_q[i] <= rank_q[i] + IdxW'(1);
        end
      end
    end
  end

  always_comb begin
    max_idx_o = '0;
    for (int unsigned i = 0; i < NumVoices; i++) begin
      if (rank_q[i] == IdxW'(NumVoices - 1)) max_idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: turns decoded MIDI note-on/note-off messages into per-voice gate commands.
// A one-entry holding register buffers one message while the FSM scans the voices; a note-on
// retriggers a voice already playing the note, else takes the lowest free voice, else steals the
// least-recently-allocated voice. A note-off gates off the first gated voice playing the note.
// Optional build macro CHANNEL_FILTER_EN: when defined, only status channel MIDI_CHANNEL is accepted.
// Ports:
//   CLK, nRST      clock, asynchronous active-low reset
//   midi_msg       [23:16] status, [15:8] note, [7:0] velocity; valid with midi_msg_rdy
//   midi_msg_rdy   one-cycle message strobe
//   voice_done     per-voice release-finished strobes
//   cmd_valid      one-cycle command strobe; cmd_voice/note/vel/gate hold until the next command
//   voice_active   per-voice allocated flags (LEDs)
//   overflow       one-cycle pulse when an incoming message is dropped
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 8,
  parameter int unsigned VIDX_W       = 3,
  parameter int unsigned MIDI_CHANNEL = 0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [23:0]           midi_msg,
  input  logic                  midi_msg_rdy,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic                  cmd_valid,
  output logic [VIDX_W-1:0]     cmd_voice,
  output logic [6:0]            cmd_note,
  output logic [6:0]            cmd_vel,
  output logic                  cmd_gate,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  overflow
);

  state_e                state_q;
  logic                  hold_full_q;
  logic [23:0]           hold_msg_q;
  logic                  overflow_q;
  logic                  pend_on_q;
  logic [6:0]            pend_note_q;
  logic [6:0]            pend_vel_q;
  logic [VIDX_W-1:0]     scan_idx_q;
  logic                  match_found_q;
  logic [VIDX_W-1:0]     match_idx_q;
  logic                  free_found_q;
  logic [VIDX_W-1:0]     free_idx_q;
  logic                  cmd_valid_q;
  logic [VIDX_W-1:0]     cmd_voice_q;
  logic [6:0]            cmd_note_q;
  logic [6:0]            cmd_vel_q;
  logic                  cmd_gate_q;
  logic [NUM_VOICES-1:0] alloc_q;
  logic [NUM_VOICES-1:0] gate_q;
  logic [6:0]            note_q [NUM_VOICES];

  // Message decode from the holding register.
  logic [3:0] msg_type;
  logic [6:0] msg_note;
  logic [6:0] msg_vel;
  logic       chan_ok;
  logic       is_on;
  logic       is_off;
  logic       unused_pad;

  assign msg_type   = hold_msg_q[MSG_TYPE_HI:MSG_TYPE_LO];
  assign msg_note   = hold_msg_q[MSG_NOTE_HI:MSG_NOTE_LO];
  assign msg_vel    = hold_msg_q[MSG_VEL_HI:MSG_VEL_LO];
  assign is_on      = (msg_type == NOTE_ON) && (msg_vel != 7'd0);
  assign is_off     = ((msg_type == NOTE_ON) && (msg_vel == 7'd0)) || (msg_type == NOTE_OFF);
  assign unused_pad = hold_msg_q[MSG_NOTE_PAD] ^ hold_msg_q[MSG_VEL_PAD];

`ifdef CHANNEL_FILTER_EN
  assign chan_ok = (hold_msg_q[MSG_CHAN_HI:MSG_CHAN_LO] == 4'(MIDI_CHANNEL));
`else
  logic [3:0] unused_chan;
  assign chan_ok     = 1'b1;
  assign unused_chan = hold_msg_q[MSG_CHAN_HI:MSG_CHAN_LO] ^ 4'(MIDI_CHANNEL);
`endif

  // Holding register: DECODE empties it, and a strobe in that same cycle refills it.
  logic hold_free;
  logic capture;

  assign hold_free = (state_q == StDecode);
  assign capture   = midi_msg_rdy && (!hold_full_q || hold_free);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hold_full_q <= 1'b0;
      hold_msg_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= midi_msg_rdy && !capture;
      if (capture) begin
        hold_full_q <= 1'b1;
        hold_msg_q  <= midi_msg;
      end else if (hold_free) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // Scan step: fold the voice under scan_idx_q into the running results.
  logic              hit;
  logic              match_now;
  logic [VIDX_W-1:0] match_idx_now;
  logic              free_now;
  logic [VIDX_W-1:0] free_idx_now;
  logic [VIDX_W-1:0] lru_max;
  logic [VIDX_W-1:0] target;
  logic              last_scan;

  always_comb begin
    hit = alloc_q[scan_idx_q] && (note_q[scan_idx_q] == pend_note_q)
          && (pend_on_q || gate_q[scan_idx_q]);
    match_now     = match_found_q || hit;
    match_idx_now = match_found_q ? match_idx_q : scan_idx_q;
    free_now      = free_found_q || !alloc_q[scan_idx_q];
    free_idx_now  = free_found_q ? free_idx_q : scan_idx_q;
    if (match_now) begin
      target = match_idx_now;
    end else if (free_now) begin
      target = free_idx_now;
    end else begin
      target = lru_max;
    end
  end

  assign last_scan = (scan_idx_q == VIDX_W'(NUM_VOICES - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= StIdle;
      pend_on_q     <= 1'b0;
      pend_note_q   <= '0;
      pend_vel_q    <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_voice_q   <= '0;
      cmd_note_q    <= '0;
      cmd_vel_q     <= '0;
      cmd_gate_q    <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // An arriving strobe is captured this edge, so DECODE can start with it.
          if (hold_full_q || midi_msg_rdy) state_q <= StDecode;
        end
        StDecode: begin
          pend_on_q     <= is_on;
          pend_note_q   <= msg_note;
          pend_vel_q    <= msg_vel;
          scan_idx_q    <= '0;
          match_found_q <= 1'b0;
          free_found_q  <= 1'b0;
          state_q       <= (chan_ok && (is_on || is_off)) ? StScan : StIdle;
        end
        StScan: begin
          match_found_q <= match_now;
          match_idx_q   <= match_idx_now;
          free_found_q  <= free_now;
          free_idx_q    <= free_idx_now;
          scan_idx_q    <= scan_idx_q + VIDX_W'(1);
          if (last_scan) begin
            // Note-on always lands somewhere; note-off needs a gated match.
            if (pend_on_q || match_now) begin
              state_q     <= StIssue;
              cmd_valid_q <= 1'b1;
              cmd_voice_q <= target;
              cmd_note_q  <= pend_note_q;
              cmd_vel_q   <= pend_vel_q;
              cmd_gate_q  <= pend_on_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StIssue: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Per-voice state is committed at the end of ISSUE; an allocation there beats voice_done.
  logic issue;
  assign issue = (state_q == StIssue);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      alloc_q <= '0;
      gate_q  <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) note_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        if (issue && (cmd_voice_q == VIDX_W'(i))) begin
          if (cmd_gate_q) begin
            alloc_q[i] <= 1'b1;
            gate_q[i]  <= 1'b1;
            note_q[i]  <= cmd_note_q;
          end else begin
            gate_q[i] <= 1'b0;
          end
        end else if (voice_done[i] && !gate_q[i]) begin
          alloc_q[i] <= 1'b0;
        end
      end
    end
  end

  lru_rank #(
    .NumVoices(NUM_VOICES),
    .IdxW     (VIDX_W)
  ) u_lru_rank (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .touch_i    (issue && cmd_gate_q),
    .touch_idx_i(cmd_voice_q),
    .max_idx_o  (lru_max)
  );

  assign cmd_valid    = cmd_valid_q;
  assign cmd_voice    = cmd_voice_q;
  assign cmd_note     = cmd_note_q;
  assign cmd_vel      = cmd_vel_q;
  assign cmd_gate     = cmd_gate_q;
  assign voice_active = alloc_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: transaction-level voice model (arrays plus an MRU-first queue),
// a per-cycle compare process, directed scenarios with literal expectations, and random traffic.
module tb_voice_allocator;

  localparam int NV = 8;
  localparam int VW = 3;
`ifdef CHANNEL_FILTER_EN
  localparam int unsigned CHAN = 2;
`else
  localparam int unsigned CHAN = 0;
`endif
  localparam logic [7:0] ST_ON  = 8'h90 | 8'(CHAN);
  localparam logic [7:0] ST_OFF = 8'h80 | 8'(CHAN);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [23:0]   msg = '0;
  logic          rdy = 1'b0;
  logic [NV-1:0] done = '0;
  logic          cmd_valid;
  logic [VW-1:0] cmd_voice;
  logic [6:0]    cmd_note;
  logic [6:0]    cmd_vel;
  logic          cmd_gate;
  logic [NV-1:0] voice_active;
  logic          overflow;

  voice_allocator #(
    .NUM_VOICES  (NV),
    .VIDX_W      (VW),
    .MIDI_CHANNEL(CHAN)
  ) dut (
    .CLK         (clk),
    .nRST        (rst_n),
    .midi_msg    (msg),
    .midi_msg_rdy(rdy),
    .voice_done  (done),
    .cmd_valid   (cmd_valid),
    .cmd_voice   (cmd_voice),
    .cmd_note    (cmd_note),
    .cmd_vel     (cmd_vel),
    .cmd_gate    (cmd_gate),
    .voice_active(voice_active),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ovf = 0;
  int last_valid_cyc = 0;
  int strobe_cyc = 0;
  bit chk_en = 1'b0;

  // Model state.
  bit         m_alloc [NV];
  bit         m_gate  [NV];
  logic [6:0] m_note  [NV];
  int         order[$];  // voice indices, most recently allocated first
  logic          e_valid;
  logic [VW-1:0] e_voice;
  logic [6:0]    e_note;
  logic [6:0]    e_vel;
  logic          e_gate;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NV-1:0] model_active();
    logic [NV-1:0] a;
    for (int i = 0; i < NV; i++) a[i] = m_alloc[i];
    return a;
  endfunction

  task automatic model_reset();
    order = {};
    for (int i = 0; i < NV; i++) begin
      m_alloc[i] = 1'b0;
      m_gate[i]  = 1'b0;
      m_note[i]  = '0;
      order.push_back(i);
    end
    e_valid = 1'b0;
    e_voice = '0;
    e_note  = '0;
    e_vel   = '0;
    e_gate  = 1'b0;
  endtask

  // What the allocator must do with message m given the current model state.
  task automatic decide(input logic [23:0] m, output bit has, output int t, output bit g);
    logic [3:0] hi;
    logic [6:0] n;
    logic [6:0] v;
    bit on;
    bit off;
    hi  = m[23:20];
    n   = m[14:8];
    v   = m[6:0];
    on  = (hi == 4'h9) && (v != 0);
    off = ((hi == 4'h9) && (v == 0)) || (hi == 4'h8);
`ifdef CHANNEL_FILTER_EN
    if (m[19:16] != 4'(CHAN)) begin
      on  = 1'b0;
      off = 1'b0;
    end
`endif
    has = 1'b0;
    g   = on;
    t   = -1;
    if (on) begin
      for (int i = 0; i < NV; i++) if (t < 0 && m_alloc[i] && m_note[i] == n) t = i;
      for (int i = 0; i < NV; i++) if (t < 0 && !m_alloc[i]) t = i;
      if (t < 0) t = order[$];
      has = 1'b1;
    end else if (off) begin
      for (int i = 0; i < NV; i++) begin
        if (t < 0 && m_alloc[i] && m_gate[i] && m_note[i] == n) t = i;
      end
      has = (t >= 0);
    end
    if (t < 0) t = 0;
  endtask

  task automatic apply_done(input logic [NV-1:0] d);
    for (int i = 0; i < NV; i++) if (d[i] && !m_gate[i]) m_alloc[i] = 1'b0;
  endtask

  task automatic apply_cmd(input int t, input bit g, input logic [6:0] n);
    int pos;
    if (g) begin
      m_alloc[t] = 1'b1;
      m_gate[t]  = 1'b1;
      m_note[t]  = n;
      pos = 0;
      foreach (order[k]) if (order[k] == t) pos = k;
      order.delete(pos);
      order.push_front(t);
    end else begin
      m_gate[t] = 1'b0;
    end
  endtask

  // One message with the allocator idle; d is driven on voice_done during the command cycle.
  task automatic send(input logic [23:0] m, input logic [NV-1:0] d);
    bit has;
    int t;
    bit g;
    decide(m, has, t, g);
    @(posedge clk); #1;
    msg = m;
    rdy = 1'b1;
    strobe_cyc = cyc;
    @(posedge clk); #1;
    rdy = 1'b0;
    msg = 24'($urandom);
    repeat (9) @(posedge clk);
    #1;
    if (has) begin
      e_valid = 1'b1;
      e_voice = VW'(t);
      e_note  = m[14:8];
      e_vel   = m[6:0];
      e_gate  = g;
    end
    done = d;
    @(posedge clk); #1;
    e_valid = 1'b0;
    done = '0;
    apply_done(d);
    if (has) apply_cmd(t, g, m[14:8]);
  endtask

  task automatic pulse_done(input logic [NV-1:0] d);
    @(posedge clk); #1;
    done = d;
    @(posedge clk); #1;
    done = '0;
    apply_done(d);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rdy = 1'b0;
    done = '0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_voice_active", voice_active, 0);
    check("rst_cmd_fields", {cmd_voice, cmd_note, cmd_vel, cmd_gate}, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmd_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (overflow === 1'b1) n_ovf++;
    if (chk_en) begin
      check("cmd_valid", cmd_valid, e_valid);
      check("voice_active", voice_active, model_active());
      check("overflow", overflow, 0);
      check("cmd_voice", cmd_voice, e_voice);
      check("cmd_note", cmd_note, e_note);
      check("cmd_vel", cmd_vel, e_vel);
      check("cmd_gate", cmd_gate, e_gate);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int o0;
    model_reset();
    do_reset();

    // First note-on: latency and fields.
    v0 = n_valid;
    send({ST_ON, 8'd60, 8'd100}, '0);
    check("first_cmd_count", n_valid - v0, 1);
    check("first_latency", last_valid_cyc - strobe_cyc, 10);
    check("first_voice", cmd_voice, 0);
    check("first_note", cmd_note, 60);
    check("first_vel", cmd_vel, 100);
    check("first_gate", cmd_gate, 1);
    check("first_active", voice_active, 8'h01);

    // Fill all voices, then steal the oldest.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      send({ST_ON, 8'(60 + i), 8'd90}, '0);
      check("fill_voice", cmd_voice, 32'(i));
    end
    check("fill_active", voice_active, 8'hff);
    send({ST_ON, 8'd70, 8'd50}, '0);
    check("steal_voice", cmd_voice, 0);
    check("steal_note", cmd_note, 70);

    // Note-off via velocity 0, then release completes.
    do_reset();
    send({ST_ON, 8'd60, 8'd100}, '0);
    send({ST_ON, 8'd60, 8'd0}, '0);
    check("off_gate", cmd_gate, 0);
    check("off_voice", cmd_voice, 0);
    check("off_active_held", voice_active, 8'h01);
    pulse_done(8'h01);
    check("off_active_freed", voice_active, 8'h00);

    // Retrigger, then retrigger a releasing voice while voice_done coincides with the command.
    do_reset();
    send({ST_ON, 8'd60, 8'd100}, '0);
    send({ST_ON, 8'd60, 8'd80}, '0);
    check("retrig_voice", cmd_voice, 0);
    check("retrig_active", voice_active, 8'h01);
    send({ST_OFF, 8'd60, 8'd64}, '0);
    send({ST_ON, 8'd60, 8'd70}, 8'h01);
    check("coincide_gate", cmd_gate, 1);
    check("coincide_active", voice_active, 8'h01);
    pulse_done(8'h01);
    check("done_while_gated", voice_active, 8'h01);

    // Three strobes back to back: one processed, one held, one dropped.
    do_reset();
    chk_en = 1'b0;
    v0 = n_valid;
    o0 = n_ovf;
    @(posedge clk); #1;
    rdy = 1'b1;
    msg = {ST_ON, 8'd61, 8'd100};
    @(posedge clk); #1;
    msg = {ST_ON, 8'd62, 8'd100};
    @(posedge clk); #1;
    msg = {ST_ON, 8'd63, 8'd100};
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("burst_cmds", n_valid - v0, 2);
    check("burst_overflow", n_ovf - o0, 1);
    check("burst_last_voice", cmd_voice, 1);
    check("burst_last_note", cmd_note, 62);
    check("burst_active", voice_active, 8'h03);

    // Reset in the middle of a scan aborts the command.
    do_reset();
    chk_en = 1'b0;
    v0 = n_valid;
    @(posedge clk); #1;
    rdy = 1'b1;
    msg = {ST_ON, 8'd60, 8'd100};
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_valid", cmd_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_cmd", n_valid - v0, 0);
    check("abort_active", voice_active, 0);

`ifdef CHANNEL_FILTER_EN
    do_reset();
    v0 = n_valid;
    send({8'h91, 8'd60, 8'd100}, '0);
    check("filter_drop", n_valid - v0, 0);
    send({8'h92, 8'd60, 8'd100}, '0);
    check("filter_pass", n_valid - v0, 1);
    check("filter_voice", cmd_voice, 0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int kind;
      logic [7:0] st;
      logic [7:0] nt;
      logic [7:0] vl;
      logic [3:0] ch;
      logic [NV-1:0] d;
      kind = int'($urandom_range(0, 9));
      ch   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(CHAN);
      nt   = 8'(60 + $urandom_range(0, 11)) | ($urandom_range(0, 1) == 1 ? 8'h80 : 8'h00);
      vl   = 8'($urandom_range(1, 127));
      if (kind <= 4) begin
        st = {4'h9, ch};
      end else if (kind <= 6) begin
        st = {4'h8, ch};
      end else if (kind == 7) begin
        st = {4'h9, ch};
        vl = 8'd0;
      end else begin
        st = {4'($urandom_range(10, 15)), ch};
        if (kind == 9) st = {4'($urandom_range(0, 7)), ch};
      end
      d = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
      send({st, nt, vl}, d);
      if ($urandom_range(0, 2) == 0) pulse_done(NV'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
